// File: rtl/par2serial_tx_if.sv
// Byte handshake between the upstream 2:1 mux and the serializer.
// The upstream side drives data and valid; the serializer answers with ready.
interface par2serial_tx_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/par2serial_tx.sv
// MSB-first byte serializer with a one-entry holding buffer. Empty slots carry IDLE_SYM.
// After reset it sends SYNC_SYMS idle symbols before it starts accepting data.
module par2serial_tx #(
    parameter int unsigned           DATA_W    = 8,
    parameter logic [DATA_W-1:0]     IDLE_SYM  = 8'hBC,
    parameter int unsigned           SYNC_SYMS = 4
) (
    input  logic            clk,
    input  logic            reset,
    par2serial_tx_if.slave  bus,
    output logic            serial_out,
    output logic            sym_start,
    output logic            sym_is_data,
    output logic            in_sync
);
    localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned SYNC_W = $clog2(SYNC_SYMS + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [SYNC_W-1:0] LAST_SYNC = SYNC_W'(SYNC_SYMS - 1);

    typedef enum logic [0:0] {StSync, StActive} state_t;

    state_t              state;
    logic [DATA_W-1:0]   hold;
    logic                hold_full;
    logic [DATA_W-1:0]   cur_sym;
    logic                cur_is_data;
    logic [CNT_W-1:0]    bit_cnt;
    logic [SYNC_W-1:0]   sync_cnt;
    logic                accept;
    logic                at_last;

    assign bus.ready_out = (state == StActive) && !hold_full;
    assign accept        = bus.valid_in && bus.ready_out;
    assign at_last       = (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            serial_out  <= 1'b0;
            sym_start   <= 1'b0;
            sym_is_data <= 1'b0;
            in_sync     <= 1'b0;
            hold        <= '0;
            hold_full   <= 1'b0;
            bit_cnt     <= '0;
            cur_sym     <= IDLE_SYM;
            cur_is_data <= 1'b0;
            sync_cnt    <= '0;
            state       <= StSync;
        end else begin
            serial_out  <= cur_sym[LAST_BIT - bit_cnt];
            sym_start   <= (bit_cnt == '0);
            sym_is_data <= cur_is_data;
            bit_cnt     <= at_last ? '0 : bit_cnt + 1'b1;

            // Symbol boundary: buffered byte first, then same-edge bypass, else idle.
            if (at_last) begin
                if (hold_full) begin
                    cur_sym     <= hold;
                    cur_is_data <= 1'b1;
                    hold_full   <= 1'b0;
                end else if (accept) begin
                    cur_sym     <= bus.data_in;
                    cur_is_data <= 1'b1;
                end else begin
                    cur_sym     <= IDLE_SYM;
                    cur_is_data <= 1'b0;
                end
            end

            // accept implies the buffer is empty, so this never collides with a drain.
            if (accept && !at_last) begin
                hold      <= bus.data_in;
                hold_full <= 1'b1;
            end

            case (state)
                StSync: begin
                    if (at_last) begin
                        sync_cnt <= sync_cnt + 1'b1;
                        if (sync_cnt == LAST_SYNC) begin
                            state   <= StActive;
                            in_sync <= 1'b1;
                        end
                    end
                end
                StActive: begin
                    in_sync <= 1'b1;
                end
                default: begin
                    state <= StSync;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_par2serial_tx.sv
// Scoreboard bench for par2serial_tx: a driver pushes accepted bytes, a monitor rebuilds
// the expected symbol stream from slot timing and compares every serial bit.
module tb_par2serial_tx;
    localparam int unsigned DATA_W    = 8;
    localparam logic [7:0]  IDLE_SYM  = 8'hBC;
    localparam int unsigned SYNC_SYMS = 4;
    localparam int unsigned SYNC_CYC  = SYNC_SYMS * DATA_W;
    localparam int unsigned TOTAL     = 900;
    localparam int unsigned RST_AT    = 400;

    typedef struct {
        logic [7:0]  d;
        int unsigned a;
    } item_t;

    logic clk = 1'b0;
    logic reset;
    logic serial_out, sym_start, sym_is_data, in_sync;

    par2serial_tx_if #(.DATA_W(DATA_W)) bus ();

    par2serial_tx #(
        .DATA_W    (DATA_W),
        .IDLE_SYM  (IDLE_SYM),
        .SYNC_SYMS (SYNC_SYMS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .serial_out  (serial_out),
        .sym_start   (sym_start),
        .sym_is_data (sym_is_data),
        .in_sync     (in_sync)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge.
    int unsigned cyc     = 0;
    logic        started = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            cyc     <= 0;
            started <= 1'b1;
        end else begin
            cyc <= cyc + 1;
        end
    end

    item_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    int          n_data = 0;
    logic [7:0]  exp_sym = IDLE_SYM;
    logic        exp_data = 1'b0;
    int unsigned mon_pos;

    // A byte accepted at edge a is loaded at the first symbol boundary edge at or after a.
    function automatic int unsigned load_edge(int unsigned a);
        return ((a + DATA_W - 1) / DATA_W) * DATA_W;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, t=%0t)",
                     name, act, exp, cyc, $time);
        end
    endtask

    // Monitor: pops the scoreboard at each symbol start and checks every bit.
    always @(negedge clk) begin
        if (started) begin
            if (cyc == 0) begin
                chk("rst_serial_out", serial_out, 0);
                chk("rst_sym_start", sym_start, 0);
                chk("rst_sym_is_data", sym_is_data, 0);
                chk("rst_in_sync", in_sync, 0);
                exp_sym  = IDLE_SYM;
                exp_data = 1'b0;
            end else begin
                mon_pos = (cyc - 1) % DATA_W;
                chk("sym_start", sym_start, (mon_pos == 0));
                chk("in_sync", in_sync, (cyc >= SYNC_CYC));
                if (mon_pos == 0) begin
                    if (sb.size() > 0 && load_edge(sb[0].a) <= cyc - 1) begin
                        chk("slot_latency", cyc - 1, load_edge(sb[0].a));
                        exp_sym  = sb[0].d;
                        exp_data = 1'b1;
                        void'(sb.pop_front());
                        n_data++;
                    end else begin
                        exp_sym  = IDLE_SYM;
                        exp_data = 1'b0;
                    end
                end
                chk("sym_is_data", sym_is_data, exp_data);
                chk("serial_bit", serial_out, exp_sym[DATA_W-1-mon_pos]);
            end
        end
    end

    // Driver: holds data/valid until a handshake, records accepted bytes with their edge.
    initial begin
        logic        hs;
        logic        busy;
        logic        exp_ready;
        int unsigned prob;
        logic [7:0]  seq;
        hs           = 1'b0;
        seq          = 8'h01;
        reset        = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        for (int k = 0; k < TOTAL; k++) begin
            @(negedge clk);
            if (cyc == 0) begin
                sb.delete();
                hs = 1'b0;
            end
            reset = (k < 3) || (k >= RST_AT && k < RST_AT + 2);

            if (k < 150)                 prob = 100;
            else if (k < 300)            prob = 20;
            else if (k < RST_AT)         prob = 60;
            else if (k < 600)            prob = 100;
            else if (k < TOTAL - 40)     prob = 35;
            else                         prob = 0;

            if (hs || !bus.valid_in) begin
                if (k < 3) begin
                    bus.valid_in = 1'b1;
                    bus.data_in  = 8'h77;
                end else if (k < 150) begin
                    bus.valid_in = 1'b1;
                    bus.data_in  = seq;
                    seq          = seq + 8'h01;
                end else begin
                    bus.valid_in = ($urandom_range(99) < prob);
                    bus.data_in  = 8'($urandom);
                end
            end

            busy = 1'b0;
            foreach (sb[i]) if (load_edge(sb[i].a) > cyc) busy = 1'b1;
            exp_ready = started && (cyc >= SYNC_CYC) && !busy;
            chk("ready_out", bus.ready_out, exp_ready);

            hs = bus.valid_in && bus.ready_out && !reset;
            if (hs) sb.push_back(item_t'{d: bus.data_in, a: cyc + 1});
        end
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("data_symbols_seen", (n_data > 50), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
